// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Lets the IF fetch port and the MEM load/store port share one single-port
//   RAM. A data access always goes before a fetch. Each RAM access uses a
//   req/ack handshake. If the RAM does not acknowledge within TIMEOUT cycles,
//   the access is forced to complete: loads and fetches return ERR_DATA and
//   the sticky bus_err flag is set. Read results are held in inst_data and
//   mem_din until the pipeline advances. The pipeline advances when stall is
//   low.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   inst_ren, inst_addr   fetch request and byte address (IF stage)
//   inst_data             buffered fetched instruction
//   mem_ren, mem_wen      load / store request (MEM stage); both set = store
//   mem_addr, mem_dout    load/store byte address and store data
//   mem_din               buffered load data
//   stall                 1 = hold every pipeline stage enable
//   ram_req, ram_we       RAM request and write enable
//   ram_addr, ram_wdata   word-aligned RAM address and write data
//   ram_rdata, ram_ack    RAM read data and one-cycle completion pulse
//   bus_err               sticky flag: some RAM access timed out
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 15,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_ren,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_data,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] mem_din,
    output logic              stall,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic              bus_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_INST
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            inst_done;
    logic            data_done;
    logic [TW-1:0]   timer;

    logic            d_wait;
    logic            i_wait;
    logic            timer_hit;
    logic            issue_data;
    logic            issue_inst;
    logic            finish;
    logic            advance;

    // The RAM works on whole words, so the byte-offset bits are not used.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr[1:0], mem_addr[1:0]};

    // An access is still outstanding while its request is up and its result
    // has not been captured during the current pipeline cycle.
    assign d_wait    = (mem_ren | mem_wen) & ~data_done;
    assign i_wait    = inst_ren & ~inst_done;
    assign stall     = d_wait | i_wait;
    assign timer_hit = (timer == TW'(TIMEOUT - 1));

    // NOTE: every output of this block gets a default before the case, so a
    // path that skips an assignment cannot infer a latch.
    always_comb begin
        state_nxt  = state;
        issue_data = 1'b0;
        issue_inst = 1'b0;
        finish     = 1'b0;
        advance    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (d_wait) begin
                    state_nxt  = ST_DATA;
                    issue_data = 1'b1;
                end else if (i_wait) begin
                    state_nxt  = ST_INST;
                    issue_inst = 1'b1;
                end else begin
                    // No access is outstanding, so stall is low and the
                    // pipeline moves on at this edge.
                    advance = 1'b1;
                end
            end
            ST_DATA, ST_INST: begin
                finish = ram_ack | timer_hit;
                if (finish) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. This keeps
    // every register sampling its pre-edge value, whatever the order of the
    // statements.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            inst_data <= '0;
            mem_din   <= '0;
            inst_done <= 1'b0;
            data_done <= 1'b0;
            timer     <= '0;
            bus_err   <= 1'b0;
        end else begin
            if (issue_data) begin
                ram_req   <= 1'b1;
                ram_we    <= mem_wen;   // ren & wen together is a store
                ram_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
                ram_wdata <= mem_dout;
                timer     <= '0;
            end

            if (issue_inst) begin
                ram_req  <= 1'b1;
                ram_we   <= 1'b0;
                ram_addr <= {inst_addr[ADDR_W-1:2], 2'b00};
                timer    <= '0;
            end

            if (advance) begin
                inst_done <= 1'b0;
                data_done <= 1'b0;
            end

            if (state != ST_IDLE) begin
                if (finish) begin
                    ram_req <= 1'b0;
                    timer   <= '0;
                    // If the ack arrives on the last allowed cycle, it still
                    // counts as a real completion.
                    if (!ram_ack) bus_err <= 1'b1;
                    if (state == ST_DATA) begin
                        data_done <= 1'b1;
                        if (!ram_we) mem_din <= ram_ack ? ram_rdata : ERR_DATA;
                    end else begin
                        inst_done <= 1'b1;
                        inst_data <= ram_ack ? ram_rdata : ERR_DATA;
                    end
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_ren;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        stall;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;
    logic        bus_err;

    int passed = 0;
    int total  = 0;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inst_ren  (inst_ren),
        .inst_addr (inst_addr),
        .inst_data (inst_data),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .stall     (stall),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_ren  = 1'b0;
        inst_addr = '0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_dout  = '0;
        ram_rdata = '0;
        ram_ack   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        inst_ren  = 1'b1;
        inst_addr = '1;
        mem_ren   = 1'b1;
        mem_wen   = 1'b1;
        mem_addr  = '1;
        mem_dout  = '1;
        ram_rdata = '1;
        ram_ack   = 1'b1;
        step();
        step();
        total++; if (ram_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", ram_req); else passed++;
        total++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %0b want 0", bus_err); else passed++;
        total++; if (inst_data !== 32'h0) $display("FAIL reset_inst_data: got %h want 0", inst_data); else passed++;
        total++; if (mem_din !== 32'h0) $display("FAIL reset_mem_din: got %h want 0", mem_din); else passed++;
        rst_n = 1'b1;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL reset_release_stall: got %0b want 1", stall); else passed++;
        step();
        // The ack that was high while idle is ignored. The store is then issued.
        total++; if (ram_req !== 1'b1 || ram_we !== 1'b1) $display("FAIL reset_first_issue: req %0b we %0b want 1 1", ram_req, ram_we); else passed++;
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        total++; if (ram_req !== 1'b0 || stall !== 1'b0) $display("FAIL no_request_idle: req %0b stall %0b want 0 0", ram_req, stall); else passed++;
    endtask

    task automatic test_fetch_only();
        inst_ren  = 1'b1;
        inst_addr = 32'h0000_0008;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL fetch_stall_c0: got %0b want 1", stall); else passed++;
        step();
        total++; if (ram_req !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'h8) $display("FAIL fetch_issue: req %0b we %0b addr %h want 1 0 00000008", ram_req, ram_we, ram_addr); else passed++;
        total++; if (stall !== 1'b1) $display("FAIL fetch_stall_c1: got %0b want 1", stall); else passed++;
        step();
        total++; if (stall !== 1'b1 || ram_req !== 1'b1) $display("FAIL fetch_stall_c2: stall %0b req %0b want 1 1", stall, ram_req); else passed++;
        ram_ack   = 1'b1;
        ram_rdata = 32'h2008_0005;
        step();
        ram_ack = 1'b0;
        total++; if (stall !== 1'b0) $display("FAIL fetch_stall_drop: got %0b want 0", stall); else passed++;
        total++; if (inst_data !== 32'h2008_0005) $display("FAIL fetch_data: got %h want 20080005", inst_data); else passed++;
        total++; if (ram_req !== 1'b0) $display("FAIL fetch_req_drop: got %0b want 0", ram_req); else passed++;
        // The next fetch is issued after the pipeline advances. The done flag
        // must have been cleared, so stall rises again for it.
        inst_addr = 32'h0000_000C;
        step();
        total++; if (stall !== 1'b1 || ram_req !== 1'b0) $display("FAIL fetch_advance: stall %0b req %0b want 1 0", stall, ram_req); else passed++;
        step();
        total++; if (ram_req !== 1'b1 || ram_addr !== 32'hC) $display("FAIL fetch_second_issue: req %0b addr %h want 1 0000000c", ram_req, ram_addr); else passed++;
        ram_ack   = 1'b1;
        ram_rdata = 32'h0000_0013;
        step();
        ram_ack  = 1'b0;
        inst_ren = 1'b0;
        step();
    endtask

    task automatic test_load_and_fetch();
        mem_ren   = 1'b1;
        mem_addr  = 32'h0000_0010;
        inst_ren  = 1'b1;
        inst_addr = 32'h0000_0004;
        step();
        total++; if (ram_req !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'h10) $display("FAIL lf_data_first: req %0b we %0b addr %h want 1 0 00000010", ram_req, ram_we, ram_addr); else passed++;
        ram_ack   = 1'b1;
        ram_rdata = 32'hAAAA_5555;
        step();
        ram_ack = 1'b0;
        total++; if (mem_din !== 32'hAAAA_5555) $display("FAIL lf_mem_din: got %h want aaaa5555", mem_din); else passed++;
        total++; if (stall !== 1'b1 || ram_req !== 1'b0) $display("FAIL lf_between: stall %0b req %0b want 1 0", stall, ram_req); else passed++;
        step();
        total++; if (ram_req !== 1'b1 || ram_addr !== 32'h4 || stall !== 1'b1) $display("FAIL lf_fetch_issue: req %0b addr %h stall %0b want 1 00000004 1", ram_req, ram_addr, stall); else passed++;
        ram_ack   = 1'b1;
        ram_rdata = 32'h0040_0093;
        step();
        ram_ack = 1'b0;
        total++; if (inst_data !== 32'h0040_0093 || stall !== 1'b0) $display("FAIL lf_fetch_done: data %h stall %0b want 00400093 0", inst_data, stall); else passed++;
        total++; if (mem_din !== 32'hAAAA_5555) $display("FAIL lf_mem_din_hold: got %h want aaaa5555", mem_din); else passed++;
        idle_inputs();
        step();
    endtask

    task automatic test_store();
        mem_ren  = 1'b1;
        mem_wen  = 1'b1;
        mem_addr = 32'h0000_0023;
        mem_dout = 32'h1234_5678;
        step();
        total++; if (ram_req !== 1'b1 || ram_we !== 1'b1) $display("FAIL store_issue: req %0b we %0b want 1 1", ram_req, ram_we); else passed++;
        total++; if (ram_addr !== 32'h20 || ram_wdata !== 32'h1234_5678) $display("FAIL store_addr_data: addr %h wdata %h want 00000020 12345678", ram_addr, ram_wdata); else passed++;
        ram_ack   = 1'b1;
        ram_rdata = 32'hFFFF_0000;
        step();
        ram_ack = 1'b0;
        total++; if (stall !== 1'b0 || ram_req !== 1'b0) $display("FAIL store_done: stall %0b req %0b want 0 0", stall, ram_req); else passed++;
        total++; if (mem_din !== 32'hAAAA_5555) $display("FAIL store_mem_din: got %h want aaaa5555", mem_din); else passed++;
        idle_inputs();
        step();
    endtask

    task automatic test_timeout();
        int cnt;
        total++; if (bus_err !== 1'b0) $display("FAIL timeout_pre_err: got %0b want 0", bus_err); else passed++;
        inst_ren  = 1'b1;
        inst_addr = 32'h0000_0100;
        step();
        cnt = 0;
        for (int i = 0; i < 40 && ram_req === 1'b1; i++) begin
            cnt++;
            step();
        end
        total++; if (cnt != 15) $display("FAIL timeout_req_cycles: got %0d want 15", cnt); else passed++;
        total++; if (inst_data !== 32'hDEAD_BEEF) $display("FAIL timeout_data: got %h want deadbeef", inst_data); else passed++;
        total++; if (bus_err !== 1'b1 || stall !== 1'b0) $display("FAIL timeout_err_stall: err %0b stall %0b want 1 0", bus_err, stall); else passed++;
        inst_ren = 1'b0;
        step();
        inst_ren  = 1'b1;
        inst_addr = 32'h0000_0200;
        step();
        ram_ack   = 1'b1;
        ram_rdata = 32'h0000_0033;
        step();
        ram_ack = 1'b0;
        total++; if (inst_data !== 32'h33 || bus_err !== 1'b1) $display("FAIL timeout_sticky: data %h err %0b want 00000033 1", inst_data, bus_err); else passed++;
        inst_ren = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_access();
        mem_ren  = 1'b1;
        mem_addr = 32'h0000_0040;
        step();
        total++; if (ram_req !== 1'b1) $display("FAIL mid_issue: got %0b want 1", ram_req); else passed++;
        rst_n   = 1'b0;
        mem_ren = 1'b0;
        step();
        total++; if (ram_req !== 1'b0 || bus_err !== 1'b0 || inst_data !== 32'h0) $display("FAIL mid_reset: req %0b err %0b idata %h want 0 0 0", ram_req, bus_err, inst_data); else passed++;
        rst_n     = 1'b1;
        ram_ack   = 1'b1;
        ram_rdata = 32'h0000_0055;
        step();
        ram_ack = 1'b0;
        total++; if (ram_req !== 1'b0 || mem_din !== 32'h0) $display("FAIL mid_late_ack: req %0b din %h want 0 0", ram_req, mem_din); else passed++;
        mem_ren = 1'b1;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL mid_data_done_clear: stall %0b want 1", stall); else passed++;
        step();
        total++; if (ram_req !== 1'b1 || ram_addr !== 32'h40) $display("FAIL mid_reissue: req %0b addr %h want 1 00000040", ram_req, ram_addr); else passed++;
        ram_ack   = 1'b1;
        ram_rdata = 32'hCAFE_F00D;
        step();
        ram_ack = 1'b0;
        total++; if (mem_din !== 32'hCAFE_F00D || stall !== 1'b0) $display("FAIL mid_reload: din %h stall %0b want cafef00d 0", mem_din, stall); else passed++;
        idle_inputs();
        step();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        step();
        test_reset();
        test_fetch_only();
        test_load_and_fetch();
        test_store();
        test_timeout();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
